// File: rtl/trap_profile_gen_pkg.sv
// Shared constants, state encoding and velocity law for the trapezoidal profile generator.
// Positions and speeds are fixed point with FRAC fractional bits.
package trap_profile_gen_pkg;

  localparam int FRAC      = 16;
  localparam int POS_ACC_W = 32 + FRAC;
  localparam int DIST_W    = 33 + FRAC;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEL  = 3'd1,
    ST_CRUISE = 3'd2,
    ST_DECEL  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Speed to apply on the coming tick. While decelerating the speed never
  // drops below one accel step, so the move always creeps to its end.
  function automatic logic [31:0] next_speed(input state_e st, input logic [31:0] v,
                                             input logic [31:0] accel, input logic [31:0] vmax);
    logic [32:0] sum;
    sum = {1'b0, v} + {1'b0, accel};
    case (st)
      ST_ACCEL: next_speed = (sum > {1'b0, vmax}) ? vmax : sum[31:0];
      ST_DECEL: next_speed = ({1'b0, v} > {accel, 1'b0}) ? (v - accel) : accel;
      default:  next_speed = v;
    endcase
  endfunction

endpackage

// File: rtl/trap_profile_gen_if.sv
// Command/status bundle between the register bank (master) and the profile generator (slave).
interface trap_profile_gen_if;

  logic signed [31:0] target_pos;
  logic        [31:0] vel_max;
  logic        [31:0] accel;
  logic               start;
  logic               abort;
  logic               load_pos;
  logic signed [31:0] pos_init;
  logic signed [31:0] desired_pos;
  logic        [31:0] cur_vel;
  logic               busy;
  logic               done;

  modport master (
    output target_pos, vel_max, accel, start, abort, load_pos, pos_init,
    input  desired_pos, cur_vel, busy, done
  );

  modport slave (
    input  target_pos, vel_max, accel, start, abort, load_pos, pos_init,
    output desired_pos, cur_vel, busy, done
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running control-tick prescaler: one-cycle tick every TICK_DIV clocks after reset release.
module tick_prescaler #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == LAST);
    cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/trap_profile_gen.sv
// Trapezoidal motion-profile generator: ramps desired_pos toward target_pos once per control tick,
// starting deceleration when the remaining distance drops to the distance spent accelerating.
module trap_profile_gen
  import trap_profile_gen_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset_n,
  trap_profile_gen_if.slave bus
);

  logic tick;

  state_e                      state_q, state_d;
  logic signed [POS_ACC_W-1:0] pos_acc_q, pos_acc_d;
  logic        [DIST_W-1:0]    dist_rem_q, dist_rem_d;
  logic        [DIST_W-1:0]    d_acc_q, d_acc_d;
  logic        [31:0]          v_q, v_d;
  logic        [31:0]          vmax_q, vmax_d;
  logic        [31:0]          accel_q, accel_d;
  logic        [31:0]          cur_vel_q, cur_vel_d;
  logic signed [31:0]          tgt_q, tgt_d;
  logic                        dir_q, dir_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic signed [31:0]          base_pos;
  logic signed [32:0]          diff;
  logic        [32:0]          mag;
  logic        [31:0]          v_next;
  logic        [31:0]          step;
  logic        [DIST_W-1:0]    rem_after;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  // A coincident load_pos is applied before the move distance is measured.
  always_comb begin
    base_pos = bus.load_pos ? bus.pos_init : pos_acc_q[POS_ACC_W-1:FRAC];
    diff     = {bus.target_pos[31], bus.target_pos} - {base_pos[31], base_pos};
    mag      = diff[32] ? -diff : diff;
  end

  always_comb begin
    v_next    = next_speed(state_q, v_q, accel_q, vmax_q);
    step      = (dist_rem_q < DIST_W'(v_next)) ? dist_rem_q[31:0] : v_next;
    rem_after = dist_rem_q - DIST_W'(step);
  end

  always_comb begin
    state_d    = state_q;
    pos_acc_d  = pos_acc_q;
    dist_rem_d = dist_rem_q;
    d_acc_d    = d_acc_q;
    v_d        = v_q;
    dir_d      = dir_q;
    tgt_d      = tgt_q;
    vmax_d     = vmax_q;
    accel_d    = accel_q;
    cur_vel_d  = cur_vel_q;
    done_d     = 1'b0;

    if (bus.abort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      v_d       = '0;
      cur_vel_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.load_pos) pos_acc_d = {bus.pos_init, {FRAC{1'b0}}};
          if (bus.start) begin
            tgt_d      = bus.target_pos;
            vmax_d     = bus.vel_max;
            accel_d    = bus.accel;
            dir_d      = diff[32];
            dist_rem_d = {mag, {FRAC{1'b0}}};
            d_acc_d    = '0;
            v_d        = '0;
            // A move that cannot progress completes in place.
            if (mag == '0 || bus.vel_max == '0 || bus.accel == '0) begin
              tgt_d   = base_pos;
              state_d = ST_DONE;
            end else begin
              state_d = ST_ACCEL;
            end
          end
        end

        ST_ACCEL, ST_CRUISE, ST_DECEL: begin
          if (tick) begin
            pos_acc_d  = dir_q ? (pos_acc_q - POS_ACC_W'(step)) : (pos_acc_q + POS_ACC_W'(step));
            dist_rem_d = rem_after;
            v_d        = v_next;
            cur_vel_d  = step;
            if (state_q == ST_ACCEL) d_acc_d = d_acc_q + DIST_W'(step);
            if (rem_after == '0) begin
              state_d = ST_DONE;
            end else if (state_q != ST_DECEL && rem_after <= d_acc_d) begin
              state_d = ST_DECEL;
            end else if (state_q == ST_ACCEL && v_next == vmax_q) begin
              state_d = ST_CRUISE;
            end
          end
        end

        ST_DONE: begin
          pos_acc_d = {tgt_q, {FRAC{1'b0}}};
          v_d       = '0;
          cur_vel_d = '0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pos_acc_q  <= '0;
      dist_rem_q <= '0;
      d_acc_q    <= '0;
      v_q        <= '0;
      dir_q      <= 1'b0;
      tgt_q      <= '0;
      vmax_q     <= '0;
      accel_q    <= '0;
      cur_vel_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_acc_q  <= pos_acc_d;
      dist_rem_q <= dist_rem_d;
      d_acc_q    <= d_acc_d;
      v_q        <= v_d;
      dir_q      <= dir_d;
      tgt_q      <= tgt_d;
      vmax_q     <= vmax_d;
      accel_q    <= accel_d;
      cur_vel_q  <= cur_vel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.desired_pos = pos_acc_q[POS_ACC_W-1:FRAC];
  assign bus.cur_vel     = cur_vel_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
